instr_mem_loader: RTL and testbench

//  Byte-stream program loader: the write-side master of the instruction memory.

---
 rtl/instr_mem_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Length-prefixed byte stream loader that writes 16-bit words into instruction memory.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the last word.
module instr_mem_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter bit         HI_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] instruction_in,
    output logic [7:0]  instruction_add,
    output logic        write_enable,
    output logic        busy,
    output logic        done,
    output logic [8:0]  word_count,
    output logic        checksum_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_B0,
        S_B1,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] word_q, word_d;
    logic        take;
    logic        start_load;

    assign take       = byte_valid && byte_ready;
    assign start_load = start && (state_q == S_IDLE || state_q == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        addr_d  = addr_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEN;
                    count_d = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            S_LEN: begin
                if (take) begin
                    // A zero length byte encodes a full 256-word image.
                    len_d   = (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
                    state_d = S_B0;
                end
            end
            S_B0: begin
                if (take) begin
                    if (HI_FIRST) word_d[15:8] = byte_in;
                    else          word_d[7:0]  = byte_in;
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (take) begin
                    if (HI_FIRST) word_d[7:0]  = byte_in;
                    else          word_d[15:8] = byte_in;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q + 9'd1;
                addr_d  = addr_q + 8'd1;
                if (count_d < len_q) begin
                    state_d = S_B0;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (take) state_d = S_DONE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xor_q <= '0;
            err_q <= 1'b0;
        end else begin
            xor_q <= xor_d;
            err_q <= err_d;
        end
    end

    // The length byte and all data bytes fold into the XOR; the checksum byte does not.
    always_comb begin
        xor_d = xor_q;
        err_d = err_q;
        if (start_load) begin
            xor_d = '0;
            err_d = 1'b0;
        end else if (take && state_q == S_CKSUM) begin
            err_d = (byte_in != xor_q);
        end else if (take) begin
            xor_d = xor_q ^ byte_in;
        end
    end

    assign checksum_err = err_q;
`else
    assign checksum_err = 1'b0;
`endif

    always_comb begin
        byte_ready   = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_q)
            S_IDLE:  busy = 1'b0;
            S_DONE:  begin
                busy = 1'b0;
                done = 1'b1;
            end
            S_WRITE: write_enable = 1'b1;
            default: byte_ready = 1'b1;
        endcase
    end

    assign instruction_in  = word_q;
    assign instruction_add = addr_q;
    assign word_count      = count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a transaction-level model.
// Honours LOADER_CHECKSUM_EN to append and check the trailing checksum byte.
module tb_instr_mem_loader;

    localparam logic [7:0] BASE     = 8'h80;
    localparam bit         HI_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic [7:0]  instruction_add;
    logic        write_enable;
    logic        busy;
    logic        done;
    logic [8:0]  word_count;
    logic        checksum_err;

    instr_mem_loader #(.BASE_ADDR(BASE), .HI_FIRST(HI_FIRST)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .instruction_in  (instruction_in),
        .instruction_add (instruction_add),
        .write_enable    (write_enable),
        .busy            (busy),
        .done            (done),
        .word_count      (word_count),
        .checksum_err    (checksum_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [8:0]  idx;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         log_q[$];
    logic [15:0] words_q[$];
    wr_t         mon_e;
    wr_t         mon_w;
    int          errors = 0;
    int          checks = 0;
    int          total_writes = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every write strobe must match the next expected word.
    always @(posedge clk) begin
        #1;
        if (reset_n && mon_en) begin
            check("busy_and_done", 32'(busy & done), 32'd0);
            check("ready_outside_busy", 32'(byte_ready & ~busy), 32'd0);
            check("write_with_ready_or_idle", 32'(write_enable & (byte_ready | ~busy)), 32'd0);
            if (write_enable) begin
                total_writes++;
                mon_w.addr = instruction_add;
                mon_w.data = instruction_in;
                mon_w.idx  = word_count;
                log_q.push_back(mon_w);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 32'(mon_w.addr), 32'(mon_e.addr));
                    check("write_data", 32'(mon_w.data), 32'(mon_e.data));
                    check("write_word_count", 32'(mon_w.idx), 32'(mon_e.idx));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
        check({tag, "_instruction_add"}, 32'(instruction_add), 32'(BASE));
        check({tag, "_instruction_in"}, 32'(instruction_in), 32'd0);
        check({tag, "_checksum_err"}, 32'(checksum_err), 32'd0);
    endtask

    task automatic reset_abort();
        int w0;
        bit we_seen;
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        start      = 1'b0;
        byte_valid = 1'b0;
        exp_q.delete();
        w0      = total_writes;
        we_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            we_seen |= write_enable;
        end
        check("no_write_in_reset", 32'(we_seen), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_write_after_reset", 32'(total_writes), 32'(w0));
        check("idle_after_reset", 32'(busy | done), 32'd0);
    endtask

    // ck_sel: 0 correct checksum, 1 randomly corrupted, 2 off by one.
    task automatic run_load(input int bp, input int ck_sel, input int rst_after);
        logic [7:0]  s[$];
        logic [7:0]  x;
        logic [7:0]  ck;
        logic [15:0] w;
        bit          exp_err;
        int          n;
        int          k;
        int          budget;
        n = words_q.size();
        s.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = words_q[i];
            exp_q.push_back('{addr: BASE + 8'(i), data: w, idx: 9'(i)});
            if (HI_FIRST) begin
                s.push_back(w[15:8]);
                s.push_back(w[7:0]);
            end else begin
                s.push_back(w[7:0]);
                s.push_back(w[15:8]);
            end
        end
        x = 8'h00;
        foreach (s[j]) x ^= s[j];
        case (ck_sel)
            0:       ck = x;
            1:       ck = x ^ 8'($urandom_range(1, 255));
            default: ck = x - 8'd1;
        endcase
        exp_err = (ck != x);
        s.push_back(ck);
`ifndef LOADER_CHECKSUM_EN
        void'(s.pop_back());
        exp_err = 1'b0;
`endif
        log_q.delete();
        @(negedge clk);
        start = 1'b1;
        k = 0;
        budget = 0;
        while (k < s.size()) begin
            @(negedge clk);
            if (rst_after > 0 && log_q.size() >= rst_after && !write_enable) begin
                reset_abort();
                return;
            end
            if (budget > 40 * s.size() + 100) begin
                check("feed_timeout", 32'(k), 32'(s.size()));
                break;
            end
            budget++;
            start      = ($urandom_range(0, 3) == 0);
            byte_valid = ($urandom_range(0, 99) >= bp);
            byte_in    = byte_valid ? s[k] : 8'($urandom);
            if (byte_valid && byte_ready) k++;
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        for (int c = 0; c < 8 && !done; c++) @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("ready_at_done", 32'(byte_ready), 32'd0);
        check("final_word_count", 32'(word_count), 32'(n));
        check("final_addr", 32'(instruction_add), 32'(BASE + 8'(n)));
        check("checksum_err", 32'(checksum_err), 32'(exp_err));
        check("writes_in_load", 32'(log_q.size()), 32'(n));
        check("writes_missing", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("done_held", 32'(done), 32'd1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Stream 02,12,34,AB,CD with valid held high.
        words_q = '{16'h1234, 16'hABCD};
        run_load(0, 0, 0);
        check("lit_writes", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) begin
            check("lit_addr0", 32'(log_q[0].addr), 32'h80);
            check("lit_data0", 32'(log_q[0].data), 32'h1234);
            check("lit_addr1", 32'(log_q[1].addr), 32'h81);
            check("lit_data1", 32'(log_q[1].data), 32'hABCD);
        end
        check("lit_word_count", 32'(word_count), 32'd2);
        check("lit_final_addr", 32'(instruction_add), 32'h82);

        // Same stream under heavy backpressure.
        run_load(60, 0, 0);

        repeat (6) begin
            words_q.delete();
            repeat ($urandom_range(1, 20)) words_q.push_back(16'($urandom));
            run_load(int'($urandom_range(0, 70)), int'($urandom_range(0, 1)), 0);
        end

        // N=0 encodes 256 words, wrapping the address through FF -> 00.
        words_q.delete();
        repeat (256) words_q.push_back(16'($urandom));
        run_load(10, 0, 0);
        check("full_writes", 32'(log_q.size()), 32'd256);
        if (log_q.size() == 256) begin
            check("full_addr_first", 32'(log_q[0].addr), 32'h80);
            check("full_addr_ff", 32'(log_q[127].addr), 32'hFF);
            check("full_addr_wrap", 32'(log_q[128].addr), 32'h00);
            check("full_addr_last", 32'(log_q[255].addr), 32'h7F);
        end
        check("full_word_count", 32'(word_count), 32'd256);

        // Reset after 3 of 5 words, then a clean single-word load.
        words_q.delete();
        repeat (5) words_q.push_back(16'($urandom));
        run_load(20, 0, 3);
        check("aborted_writes", 32'(log_q.size()), 32'd3);
        words_q = '{16'h5A6B};
        run_load(0, 0, 0);
        check("after_abort_writes", 32'(log_q.size()), 32'd1);
        if (log_q.size() == 1) begin
            check("after_abort_addr", 32'(log_q[0].addr), 32'h80);
            check("after_abort_data", 32'(log_q[0].data), 32'h5A6B);
        end

`ifdef LOADER_CHECKSUM_EN
        // Stream 01,12,34 folds to 27; 26 must be flagged.
        words_q = '{16'h1234};
        run_load(0, 0, 0);
        check("lit_cksum_ok", 32'(checksum_err), 32'd0);
        run_load(30, 2, 0);
        check("lit_cksum_bad", 32'(checksum_err), 32'd1);
        check("lit_cksum_bad_done", 32'(done), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
